// File: rtl/forwarding_pkg.sv
// Shared encodings for the forwarding / load-use hazard unit: bypass selects and stall FSM states.
package forwarding_pkg;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_MEM  = 2'b10;
  localparam logic [1:0] FWD_MEM_WB  = 2'b01;
  localparam logic [1:0] FWD_WB_HIST = 2'b11;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } haz_state_e;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Pipeline-side bundle for the hazard unit: stage register fields in, bypass/stall controls out.
interface forwarding_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int CNT_W      = 16
);

  logic                            ext_stall_in;
  logic [NUM_SRC*REG_ADDR_W-1:0]   ID_EX_src_in;
  logic [NUM_SRC*REG_ADDR_W-1:0]   IF_ID_src_in;
  logic [REG_ADDR_W-1:0]           ID_EX_reg_destination_in;
  logic                            ID_EX_WB_in;
  logic                            ID_EX_mem_read_in;
  logic [REG_ADDR_W-1:0]           EX_MEM_reg_destination_in;
  logic                            EX_MEM_WB_in;
  logic [REG_ADDR_W-1:0]           MEM_WB_reg_destination_in;
  logic                            MEM_WB_WB_in;
  logic [2*NUM_SRC-1:0]            Forward_out;
  logic                            stall_out;
  logic                            bubble_out;
  logic [CNT_W-1:0]                fwd_count_out;
  logic [CNT_W-1:0]                stall_count_out;

  modport master (
    output ext_stall_in, ID_EX_src_in, IF_ID_src_in,
    output ID_EX_reg_destination_in, ID_EX_WB_in, ID_EX_mem_read_in,
    output EX_MEM_reg_destination_in, EX_MEM_WB_in,
    output MEM_WB_reg_destination_in, MEM_WB_WB_in,
    input  Forward_out, stall_out, bubble_out, fwd_count_out, stall_count_out
  );

  modport slave (
    input  ext_stall_in, ID_EX_src_in, IF_ID_src_in,
    input  ID_EX_reg_destination_in, ID_EX_WB_in, ID_EX_mem_read_in,
    input  EX_MEM_reg_destination_in, EX_MEM_WB_in,
    input  MEM_WB_reg_destination_in, MEM_WB_WB_in,
    output Forward_out, stall_out, bubble_out, fwd_count_out, stall_count_out
  );

endinterface

// File: rtl/forwarding_hazard_unit_fwd_select_lane.sv
// One EX-stage source operand: compare against each producer and priority-encode the bypass select.
module fwd_select_lane
  import forwarding_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic [REG_ADDR_W-1:0] ex_mem_dest_i,
  input  logic                  ex_mem_wb_i,
  input  logic [REG_ADDR_W-1:0] mem_wb_dest_i,
  input  logic                  mem_wb_wb_i,
  input  logic [REG_ADDR_W-1:0] hist_dest_i,
  input  logic                  hist_valid_i,
  output logic [1:0]            sel_o
);

  // A nonzero source implies any matching dest is nonzero too, so r0 never forwards.
  always_comb begin
    sel_o = FWD_RF;
    if (src_i != '0) begin
      if (ex_mem_wb_i && (ex_mem_dest_i == src_i)) begin
        sel_o = FWD_EX_MEM;
      end else if (mem_wb_wb_i && (mem_wb_dest_i == src_i)) begin
        sel_o = FWD_MEM_WB;
      end else if (hist_valid_i && (hist_dest_i == src_i)) begin
        sel_o = FWD_WB_HIST;
      end
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand-forwarding and load-use stall controller for the 5-stage pipeline.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module forwarding_hazard_unit
  import forwarding_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  forwarding_hazard_unit_if.slave bus
);

  localparam int CNT_BITS = $clog2(LOAD_LAT + 1);

  logic [2*NUM_SRC-1:0]  fwd_sel;
  logic                  hist_valid_q, hist_valid_d;
  logic [REG_ADDR_W-1:0] hist_dest_q, hist_dest_d;
  haz_state_e            state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  src_hit;
  logic                  hazard;
  logic                  stall_w;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fwd_select_lane #(
      .REG_ADDR_W(REG_ADDR_W)
    ) u_lane (
      .src_i        (bus.ID_EX_src_in[i*REG_ADDR_W +: REG_ADDR_W]),
      .ex_mem_dest_i(bus.EX_MEM_reg_destination_in),
      .ex_mem_wb_i  (bus.EX_MEM_WB_in),
      .mem_wb_dest_i(bus.MEM_WB_reg_destination_in),
      .mem_wb_wb_i  (bus.MEM_WB_WB_in),
      .hist_dest_i  (hist_dest_q),
      .hist_valid_i (hist_valid_q),
      .sel_o        (fwd_sel[2*i +: 2])
    );
  end

  assign bus.Forward_out = fwd_sel;

  // History slot holds the value just retired, covering a same-cycle regfile write/read.
  assign hist_valid_d = bus.MEM_WB_WB_in && (bus.MEM_WB_reg_destination_in != '0);
  assign hist_dest_d  = bus.MEM_WB_reg_destination_in;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      hist_valid_q <= 1'b0;
      hist_dest_q  <= '0;
    end else if (!bus.ext_stall_in) begin
      hist_valid_q <= hist_valid_d;
      hist_dest_q  <= hist_dest_d;
    end
  end

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.IF_ID_src_in[i*REG_ADDR_W +: REG_ADDR_W] == bus.ID_EX_reg_destination_in) begin
        src_hit = 1'b1;
      end
    end
  end

  assign hazard = bus.ID_EX_mem_read_in && bus.ID_EX_WB_in &&
                  (bus.ID_EX_reg_destination_in != '0) && src_hit;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (!bus.ext_stall_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first bubble comes from RUN itself, so STALL only covers the remaining LOAD_LAT-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_w = 1'b0;
    case (state_q)
      RUN: begin
        stall_w = hazard;
        if (hazard && (LOAD_LAT > 1)) begin
          state_d = STALL;
          cnt_d   = CNT_BITS'(LOAD_LAT - 1);
        end
      end
      STALL: begin
        stall_w = 1'b1;
        if (cnt_q == CNT_BITS'(1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.stall_out  = stall_w;
  assign bus.bubble_out = stall_w;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign fwd_cnt_d   = (|fwd_sel) ? sat_inc(fwd_cnt_q) : fwd_cnt_q;
  assign stall_cnt_d = stall_w ? sat_inc(stall_cnt_q) : stall_cnt_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (!bus.ext_stall_in) begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fwd_count_out   = fwd_cnt_q;
  assign bus.stall_count_out = stall_cnt_q;
`else
  assign bus.fwd_count_out   = '0;
  assign bus.stall_count_out = '0;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit (LOAD_LAT=3); counter checks adapt to HAZ_PERF_CNT_EN.
module tb_forwarding_hazard_unit;
  import forwarding_pkg::*;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  forwarding_hazard_unit_if #(.REG_ADDR_W(5), .NUM_SRC(2), .CNT_W(16)) bif ();

  forwarding_hazard_unit #(
    .REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)
  ) dut (
    .clk_in  (clk),
    .reset_in(rst),
    .bus     (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bif.ext_stall_in              = 1'b0;
    bif.ID_EX_src_in              = '0;
    bif.IF_ID_src_in              = '0;
    bif.ID_EX_reg_destination_in  = '0;
    bif.ID_EX_WB_in               = 1'b0;
    bif.ID_EX_mem_read_in         = 1'b0;
    bif.EX_MEM_reg_destination_in = '0;
    bif.EX_MEM_WB_in              = 1'b0;
    bif.MEM_WB_reg_destination_in = '0;
    bif.MEM_WB_WB_in              = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
  endtask

  task automatic load_use_r5();
    bif.ID_EX_reg_destination_in = 5'd5;
    bif.ID_EX_WB_in              = 1'b1;
    bif.ID_EX_mem_read_in        = 1'b1;
    bif.IF_ID_src_in             = {5'd5, 5'd0};
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #12;
    checks++;
    if (bif.stall_out !== 1'b0 || bif.bubble_out !== 1'b0) begin
      errors++; $display("FAIL reset_stall got=%b/%b exp=0/0", bif.stall_out, bif.bubble_out);
    end
    checks++;
    if (dut.state_q !== RUN || dut.hist_valid_q !== 1'b0 || dut.hist_dest_q !== 5'd0) begin
      errors++; $display("FAIL reset_state got st=%0d hv=%b hd=%0d exp 0/0/0",
                         dut.state_q, dut.hist_valid_q, dut.hist_dest_q);
    end
    checks++;
    if (bif.fwd_count_out !== 16'd0 || bif.stall_count_out !== 16'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bif.fwd_count_out, bif.stall_count_out);
    end
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_ex_mem();
    clear_inputs();
    bif.EX_MEM_reg_destination_in = 5'd3;
    bif.EX_MEM_WB_in              = 1'b1;
    bif.ID_EX_src_in              = {5'd0, 5'd3};
    #1;
    checks++;
    if (bif.Forward_out !== 4'b0010 || bif.stall_out !== 1'b0) begin
      errors++; $display("FAIL ex_mem_lane0 got=%b stall=%b exp=0010 stall=0", bif.Forward_out, bif.stall_out);
    end
    bif.ID_EX_src_in = {5'd3, 5'd3};
    #1;
    checks++;
    if (bif.Forward_out !== 4'b1010) begin
      errors++; $display("FAIL ex_mem_both got=%b exp=1010", bif.Forward_out);
    end
    bif.EX_MEM_WB_in              = 1'b0;
    bif.MEM_WB_reg_destination_in = 5'd9;
    bif.MEM_WB_WB_in              = 1'b1;
    bif.ID_EX_src_in              = {5'd3, 5'd9};
    #1;
    checks++;
    if (bif.Forward_out !== 4'b0001) begin
      errors++; $display("FAIL mem_wb_lane0 got=%b exp=0001", bif.Forward_out);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    bif.EX_MEM_reg_destination_in = 5'd4;
    bif.EX_MEM_WB_in              = 1'b1;
    bif.MEM_WB_reg_destination_in = 5'd4;
    bif.MEM_WB_WB_in              = 1'b1;
    bif.ID_EX_src_in              = {5'd4, 5'd0};
    #1;
    checks++;
    if (bif.Forward_out !== 4'b1000) begin
      errors++; $display("FAIL prio_ex_over_mem got=%b exp=1000", bif.Forward_out);
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    bif.ID_EX_WB_in   = 1'b1;
    bif.EX_MEM_WB_in  = 1'b1;
    bif.MEM_WB_WB_in  = 1'b1;
    bif.ID_EX_mem_read_in = 1'b1;
    #1;
    checks++;
    if (bif.Forward_out !== 4'b0000 || bif.stall_out !== 1'b0) begin
      errors++; $display("FAIL zero_reg_fwd got=%b stall=%b exp=0000 stall=0", bif.Forward_out, bif.stall_out);
    end
    @(posedge clk); #1;
    checks++;
    if (dut.hist_valid_q !== 1'b0) begin
      errors++; $display("FAIL zero_reg_hist got=%b exp=0", dut.hist_valid_q);
    end
  endtask

  task automatic test_wb_hist();
    clear_inputs();
    bif.MEM_WB_reg_destination_in = 5'd7;
    bif.MEM_WB_WB_in              = 1'b1;
    @(posedge clk); #1;
    bif.ID_EX_src_in = {5'd0, 5'd7};
    #1;
    checks++;
    if (bif.Forward_out !== 4'b0001) begin
      errors++; $display("FAIL hist_mem_wb_wins got=%b exp=0001", bif.Forward_out);
    end
    bif.MEM_WB_WB_in              = 1'b0;
    bif.MEM_WB_reg_destination_in = 5'd0;
    #1;
    checks++;
    if (bif.Forward_out !== 4'b0011) begin
      errors++; $display("FAIL hist_lane0 got=%b exp=0011", bif.Forward_out);
    end
    bif.ID_EX_src_in = {5'd7, 5'd7};
    #1;
    checks++;
    if (bif.Forward_out !== 4'b1111) begin
      errors++; $display("FAIL hist_both got=%b exp=1111", bif.Forward_out);
    end
    bif.ext_stall_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bif.Forward_out !== 4'b1111) begin
      errors++; $display("FAIL hist_frozen_hold got=%b exp=1111", bif.Forward_out);
    end
    bif.ext_stall_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bif.Forward_out !== 4'b0000) begin
      errors++; $display("FAIL hist_expire got=%b exp=0000", bif.Forward_out);
    end
  endtask

  task automatic test_no_hazard();
    clear_inputs();
    load_use_r5();
    bif.ID_EX_mem_read_in = 1'b0;
    #1;
    checks++;
    if (bif.stall_out !== 1'b0) begin
      errors++; $display("FAIL nohaz_not_load got=%b exp=0", bif.stall_out);
    end
    bif.ID_EX_mem_read_in = 1'b1;
    bif.IF_ID_src_in      = {5'd6, 5'd4};
    #1;
    checks++;
    if (bif.stall_out !== 1'b0) begin
      errors++; $display("FAIL nohaz_no_match got=%b exp=0", bif.stall_out);
    end
    bif.IF_ID_src_in = {5'd6, 5'd5};
    #1;
    checks++;
    if (bif.stall_out !== 1'b1 || bif.bubble_out !== 1'b1) begin
      errors++; $display("FAIL haz_lane0 got=%b/%b exp=1/1", bif.stall_out, bif.bubble_out);
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_load_use();
    logic exp_stall [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    clear_inputs();
    load_use_r5();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bif.stall_out !== exp_stall[c] || bif.bubble_out !== exp_stall[c]) begin
        errors++; $display("FAIL load_use_c%0d got=%b/%b exp=%b", c, bif.stall_out, bif.bubble_out, exp_stall[c]);
      end
      @(posedge clk); #1;
      bif.ID_EX_mem_read_in        = 1'b0;
      bif.ID_EX_WB_in              = 1'b0;
      bif.ID_EX_reg_destination_in = 5'd0;
    end
    checks++;
    if (bif.stall_count_out !== (PERF ? 16'd3 : 16'd0) || bif.fwd_count_out !== 16'd0) begin
      errors++; $display("FAIL load_use_counts got=%0d/%0d exp=%0d/0", bif.stall_count_out,
                         bif.fwd_count_out, PERF ? 3 : 0);
    end
  endtask

  task automatic test_ext_stall();
    do_reset();
    clear_inputs();
    load_use_r5();
    bif.ext_stall_in = 1'b1;
    #1;
    checks++;
    if (bif.stall_out !== 1'b1) begin
      errors++; $display("FAIL ext_comb_stall got=%b exp=1", bif.stall_out);
    end
    @(posedge clk); #1;
    checks++;
    if (dut.state_q !== RUN || bif.stall_out !== 1'b1 || bif.stall_count_out !== 16'd0) begin
      errors++; $display("FAIL ext_frozen_run got st=%0d stall=%b cnt=%0d exp 0/1/0",
                         dut.state_q, bif.stall_out, bif.stall_count_out);
    end
    bif.ext_stall_in = 1'b0;
    @(posedge clk); #1;
    clear_inputs();
    bif.ext_stall_in = 1'b1;
    #1;
    checks++;
    if (dut.state_q !== STALL || bif.stall_out !== 1'b1) begin
      errors++; $display("FAIL ext_enter_stall got st=%0d stall=%b exp 1/1", dut.state_q, bif.stall_out);
    end
    @(posedge clk); #1;
    bif.ext_stall_in = 1'b0;
    checks++;
    if (dut.cnt_q !== 2'd2 || bif.stall_out !== 1'b1) begin
      errors++; $display("FAIL ext_cnt_hold got cnt=%0d stall=%b exp 2/1", dut.cnt_q, bif.stall_out);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.stall_out !== 1'b1) begin
      errors++; $display("FAIL ext_last_bubble got=%b exp=1", bif.stall_out);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.stall_out !== 1'b0 || bif.stall_count_out !== (PERF ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL ext_done got stall=%b cnt=%0d exp 0/%0d", bif.stall_out,
                         bif.stall_count_out, PERF ? 3 : 0);
    end
  endtask

  task automatic test_fwd_count();
    do_reset();
    clear_inputs();
    bif.EX_MEM_reg_destination_in = 5'd3;
    bif.EX_MEM_WB_in              = 1'b1;
    bif.ID_EX_src_in              = {5'd3, 5'd3};
    @(posedge clk); #1;
    @(posedge clk); #1;
    bif.ID_EX_src_in = '0;
    @(posedge clk); #1;
    checks++;
    if (bif.fwd_count_out !== (PERF ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL fwd_count got=%0d exp=%0d", bif.fwd_count_out, PERF ? 2 : 0);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    clear_inputs();
    load_use_r5();
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    checks++;
    if (dut.state_q !== STALL || bif.stall_out !== 1'b1) begin
      errors++; $display("FAIL mid_stall_pre got st=%0d stall=%b exp 1/1", dut.state_q, bif.stall_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bif.stall_out !== 1'b0 || bif.bubble_out !== 1'b0 || dut.state_q !== RUN) begin
      errors++; $display("FAIL mid_stall_async got stall=%b bub=%b st=%0d exp 0/0/0",
                         bif.stall_out, bif.bubble_out, dut.state_q);
    end
    checks++;
    if (bif.stall_count_out !== 16'd0) begin
      errors++; $display("FAIL mid_stall_count got=%0d exp=0", bif.stall_count_out);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bif.stall_out !== 1'b0) begin
      errors++; $display("FAIL mid_stall_after got=%b exp=0", bif.stall_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    test_reset();
    test_ex_mem();
    test_priority();
    test_zero_reg();
    test_wb_hist();
    test_no_hazard();
    test_load_use();
    test_ext_stall();
    test_fwd_count();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
